// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, state encoding and divide-by-zero constant for the divider
package div_pkg;

  localparam int DIV_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_W-1:0] DIV0_QUOT = 4'hF;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-and-subtract step
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W:0]   r_i,
  input  logic [DIV_W-1:0] q_i,
  input  logic [DIV_W-1:0] d_i,
  output logic [DIV_W:0]   r_o,
  output logic [DIV_W-1:0] q_o
);

  logic [DIV_W:0] r_sh;
  logic [DIV_W:0] sub_b;
  logic [DIV_W:0] diff;
  logic           borrow_n;

  // The partial remainder stays below D before the shift, so its MSB is always 0 here
  logic unused_r_msb;
  assign unused_r_msb = r_i[DIV_W];

  // Shift in the next dividend bit, ripple-subtract D (add ~D + 1), restore on borrow
  always_comb begin
    r_sh     = {r_i[DIV_W-1:0], q_i[DIV_W-1]};
    sub_b    = ~{1'b0, d_i};
    diff     = '0;
    borrow_n = 1'b1;
    for (int i = 0; i <= DIV_W; i++) begin
      diff[i]  = r_sh[i] ^ sub_b[i] ^ borrow_n;
      borrow_n = (r_sh[i] & sub_b[i]) | (borrow_n & (r_sh[i] ^ sub_b[i]));
    end
    if (borrow_n) begin
      r_o = diff;
      q_o = {q_i[DIV_W-2:0], 1'b1};
    end else begin
      r_o = r_sh;
      q_o = {q_i[DIV_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/four_bit_divider_sequential.sv
// rtl/four_bit_divider_sequential.sv - 4-bit sequential restoring divider; START_SYNC_EN adds a 2-flop button synchronizer
module four_bit_divider_sequential
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] SW,
  input  logic       BTNC,
  output logic [9:0] LED
);

  div_state_t       state_q, state_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [DIV_W-1:0] d_q, d_d;
  logic [DIV_W:0]   r_q, r_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [9:0]       led_q, led_d;
  logic             btn_q;
  logic             arm_q;
  logic             btn_in;
  logic             start;
  logic [DIV_W:0]   step_r;
  logic [DIV_W-1:0] step_q;

`ifdef START_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= BTNC;
      sync2_q <= sync1_q;
    end
  end

  assign btn_in = sync2_q;
`else
  assign btn_in = BTNC;
`endif

  // Edge-detect register; arm_q stays low until the raw button is seen released after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      btn_q <= btn_in;
      arm_q <= arm_q | ~BTNC;
    end
  end

  assign start = btn_in & ~btn_q & arm_q;

  div_step u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  // Datapath and FSM state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  // Next-state: load on start, iterate one step per cycle, publish result on the 4th step
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_d   = SW[7:4];
          d_d   = SW[3:0];
          r_d   = '0;
          cnt_d = '0;
          if (SW[3:0] == '0) begin
            state_d = DONE;
            led_d   = {1'b1, 1'b0, SW[7:4], DIV0_QUOT};
          end else begin
            state_d  = RUN;
            led_d[8] = 1'b1;
            led_d[9] = 1'b0;
          end
        end
      end
      RUN: begin
        q_d   = step_q;
        r_d   = step_r;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d    = DONE;
          led_d[8]   = 1'b0;
          led_d[7:0] = {step_r[DIV_W-1:0], step_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign LED = led_q;

endmodule

// File: tb/tb_four_bit_divider_sequential.sv
// tb/tb_four_bit_divider_sequential.sv - self-checking bench for the sequential divider
module tb_four_bit_divider_sequential;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] SW;
  logic       BTNC;
  logic [9:0] LED;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef START_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  four_bit_divider_sequential dut (
    .clk  (clk),
    .rst  (rst),
    .SW   (SW),
    .BTNC (BTNC),
    .LED  (LED)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_led(input int a, input int b);
    logic [3:0] qq, rr;
    if (b == 0) begin
      rr = 4'(a);
      return {1'b1, 1'b0, rr, 4'hF};
    end
    qq = 4'(a / b);
    rr = 4'(a % b);
    return {2'b00, rr, qq};
  endfunction

  // Press the button and advance to just after the load edge E0, then release
  task automatic press_to_e0(input int a, input int b);
    SW   = {4'(a), 4'(b)};
    BTNC = 1'b1;
    repeat (LAT) tick();
    tick();
    BTNC = 1'b0;
  endtask

  task automatic do_div(input int a, input int b, input string tag);
    logic [9:0] exp;
    exp = ref_led(a, b);
    press_to_e0(a, b);
    if (b == 0) begin
      chk({tag, "_div0_e0"}, LED, exp);
      tick();
      chk({tag, "_div0_hold"}, LED, exp);
    end else begin
      chk({tag, "_busy_e0"}, {9'b0, LED[8]}, 10'd1);
      for (int k = 1; k <= 3; k++) begin
        tick();
        chk({tag, "_busy_mid"}, {9'b0, LED[8]}, 10'd1);
      end
      tick();
      chk({tag, "_result"}, LED, exp);
    end
  endtask

  initial begin
    int a, b;
    rst  = 1'b1;
    SW   = 8'h00;
    BTNC = 1'b0;
    tick();
    tick();
    chk("reset_led", LED, 10'h000);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_led", LED, 10'h000);

    do_div(13, 3, "d13_3");
    do_div(15, 1, "d15_1");
    do_div(5, 7, "d5_7");
    do_div(9, 0, "d9_0");
    do_div(8, 2, "d8_2");

    // Second press and operand change during RUN must not disturb the division
    press_to_e0(6, 4);
    SW = {4'd15, 4'd1};
    tick();
    BTNC = 1'b1;
    tick();
    tick();
    tick();
    chk("ignore_result", LED, ref_led(6, 4));
    BTNC = 1'b0;
    repeat (4) tick();
    chk("ignore_hold", LED, ref_led(6, 4));

    // Asynchronous reset mid-RUN with the button held through release
    press_to_e0(13, 3);
    BTNC = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1 chk("rst_async", LED, 10'h000);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("held_no_start", LED, 10'h000);
    end
    BTNC = 1'b0;
    repeat (3) tick();
    chk("after_rst_idle", LED, 10'h000);
    do_div(13, 3, "post_rst");

    // Randomized back-to-back divisions against the arithmetic reference
    for (int n = 0; n < 24; n++) begin
      a = int'($urandom_range(15));
      b = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15, 1));
      do_div(a, b, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/four_bit_divider_sequential.md
# four_bit_divider_sequential

Sequential 4-bit unsigned restoring divider for the board-level arithmetic lab set. It is the inverse-direction companion of the combinational switch-driven adder/subtractor: instead of one add or subtract, it runs repeated shift-and-subtract steps over four clock cycles. Operands come from the slide switches. Quotient, remainder and status drive the LEDs, and a push-button starts each division.

## Interface
Parameters:
- none. Width is fixed at 4 by the package constant `DIV_W`.

Ports:
- `clk`  input  1  board clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `SW`  input  8  `SW[7:4]` is the dividend, `SW[3:0]` is the divisor.
- `BTNC`  input  1  start request; level input, the rising edge is detected internally.
- `LED`  output  10  `LED[3:0]` quotient, `LED[7:4]` remainder, `LED[8]` busy, `LED[9]` divide-by-zero.

## Operation
- Start detect: `btn_q` registers `BTNC` every cycle; `start = BTNC & ~btn_q`.
- FSM states (package enum): IDLE, RUN, DONE.
- IDLE or DONE with `start` asserted:
  - latch dividend into `Q` (4b) and divisor into `D` (4b);
  - clear the partial remainder `R` (5b) and step counter `cnt` (2b);
  - next state is RUN and busy goes to 1.
  - If the latched divisor is 0: skip RUN and go straight to DONE. Quotient = 4'hF, remainder = dividend, `LED[9]` = 1.
- RUN step, once per cycle:
  - `R' = {R[3:0], Q[3]}` and `Q' = {Q[2:0], 1'b0}`;
  - if `R' >= {1'b0, D}`: `R' -= D` and `Q'[0] = 1`.
  - After the 4th step (`cnt == 3`): state DONE, busy = 0, result registers load `Q'` and `R'[3:0]`.
- `R` never exceeds 5 bits, because the partial remainder is always below `D` before the shift.
- DONE: results are held until the next `start`. `LED[9]` holds its value until the next load; a non-zero load clears it.
- `start` during RUN is ignored. `SW` changes after the load edge do not affect the running division.
- Outputs are registered; `LED` depends on no combinational path from `SW`.

## Timing
- Reset values: state IDLE; `LED` = 10'b0; `Q`, `R`, `D`, `cnt`, `btn_q` all 0.
- Let E0 be the edge where `start` is sampled (operand load).
  - Busy is high after E0.
  - Steps run on E1 through E4.
  - Results are valid and busy is low after E4, giving a latency of 4 cycles from the load edge.
- Divide-by-zero: result and flag are valid after E0 (latency 0); busy never rises.
- Back-to-back: a `start` in DONE is accepted on the same cycle, so a new division can load the cycle after results appear.
- `rst` asserted mid-RUN clears everything immediately, with no completion. After release the block is in IDLE and needs a fresh rising edge; a button held through reset is not a start.

## Configuration
- `START_SYNC_EN` defined:
  - `BTNC` passes through a 2-flop synchronizer before the edge detect;
  - start-to-load latency grows by 2 cycles;
  - the synchronizer flops reset to 0.
- `START_SYNC_EN` not defined: `BTNC` feeds the edge detect directly, with timing as specified above.

## Structure
- Package `div_pkg`:
  - `DIV_W` = 4;
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t`;
  - constant `DIV0_QUOT` = 4'hF.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: `R` (5b), `Q` (4b), `D` (4b).
  - Outputs: next `R` and next `Q`.
  - Implemented with the existing full-adder/XOR subtract style; instantiated once and iterated by the FSM.

## Test plan
- `SW` = {13, 3}, pulse `BTNC` → busy for 4 cycles, then `LED[3:0]` = 4, `LED[7:4]` = 1, `LED[9]` = 0.
- `SW` = {15, 1} → quotient 15, remainder 0. `SW` = {5, 7} → quotient 0, remainder 5.
- `SW` = {9, 0} → one cycle after start: `LED[3:0]` = F, `LED[7:4]` = 9, `LED[9]` = 1, busy never 1. A following {8, 2} division clears `LED[9]` and gives 4 r 0.
- Second `BTNC` edge and `SW` change during RUN → ignored; the original operands' result appears at E4.
- `rst` pulsed at E2 of a RUN → `LED` = 0, state IDLE. `BTNC` held high through reset release starts nothing.
- With `START_SYNC_EN`: {13, 3} result appears 6 cycles after the `BTNC` rise instead of 4.
